// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared constants for the digit renderer
// Holds position codes, segment element codes, the 7-segment glyph table and
// pixel colours. Macro DIGIT_RENDER_BG_EN selects a dim blue cell background
// instead of black.
package scoreboard_pkg;

    localparam logic [2:0] POS_CELL0 = 3'b000;
    localparam logic [2:0] POS_CELL1 = 3'b001;
    localparam logic [2:0] POS_NULL  = 3'b111;

    localparam logic [3:0] ID_BLANK  = 4'b1010;

    // Bit index of each segment inside a glyph mask.
    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F = 3'd5,
        SEG_G = 3'd6
    } seg_e;

    localparam logic [2:0] FG_RED   = 3'b111;
    localparam logic [2:0] FG_GREEN = 3'b111;
    localparam logic [1:0] FG_BLUE  = 2'b11;

    localparam logic [2:0] BG_RED   = 3'b000;
    localparam logic [2:0] BG_GREEN = 3'b000;
`ifdef DIGIT_RENDER_BG_EN
    localparam logic [1:0] BG_BLUE  = 2'b01;
`else
    localparam logic [1:0] BG_BLUE  = 2'b00;
`endif

    // Glyph masks, bit order g f e d c b a; ids above 9 light nothing.
    function automatic logic [6:0] seg_lookup(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

endpackage

// File: rtl/digit_render_seg_decode.sv
// rtl/digit_render_seg_decode.sv - combinational segment hit test for one cell
// Ports:
//   digit  - glyph id (0-9, anything else is blank)
//   x, y   - local pixel coordinate inside the cell
//   pix_on - 1 when (x, y) lies on a lit segment of the glyph
module seg_decode
    import scoreboard_pkg::*;
#(
    parameter int CELL_W = 30,
    parameter int CELL_H = 40,
    parameter int SEG_T  = 4,
    parameter int XW     = $clog2(CELL_W),
    parameter int YW     = $clog2(CELL_H)
) (
    input  logic [3:0]    digit,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic          pix_on
);

    localparam int MID_LO = CELL_H / 2 - SEG_T / 2;
    localparam int MID_HI = CELL_H / 2 + SEG_T / 2;

    logic signed [31:0] xi;
    logic signed [31:0] yi;
    logic               h_span;
    logic               left;
    logic               right;
    logic [6:0]         hit;

    always_comb begin
        xi     = 32'(x);
        yi     = 32'(y);
        // Horizontal bars stop short of the vertical bars so corners stay dark.
        h_span = (xi >= SEG_T) && (xi < CELL_W - SEG_T);
        left   = (xi < SEG_T);
        right  = (xi >= CELL_W - SEG_T);
        hit    = '0;
        hit[SEG_A] = (yi < SEG_T) && h_span;
        hit[SEG_D] = (yi >= CELL_H - SEG_T) && h_span;
        hit[SEG_G] = (yi >= MID_LO) && (yi < MID_HI) && h_span;
        hit[SEG_F] = left  && (yi >= SEG_T) && (yi < MID_LO);
        hit[SEG_B] = right && (yi >= SEG_T) && (yi < MID_LO);
        hit[SEG_E] = left  && (yi >= MID_HI) && (yi < CELL_H - SEG_T);
        hit[SEG_C] = right && (yi >= MID_HI) && (yi < CELL_H - SEG_T);
        pix_on = |(hit & seg_lookup(digit));
    end

endmodule

// File: rtl/digit_render.sv
// rtl/digit_render.sv - two-cell 7-segment digit pixel renderer
// Ports:
//   clk_dr          - clock, rising edge
//   rst_dr          - synchronous active-high reset
//   enable_dr       - module enable; low clears counters and forces outputs 0
//   mem_position_dr - cell select: 000 cell 0, 001 cell 1, others null
//   mem_id_dr       - digit id 0-9, 1010 blank
//   red_px_dr, green_px_dr, blue_px_dr - registered pixel colour
//   px_valid_dr     - registered, high when the pixel belongs to a cell
// Macro DIGIT_RENDER_BG_EN (via scoreboard_pkg) selects the background colour.
module digit_render
    import scoreboard_pkg::*;
#(
    parameter int CELL_W = 30,
    parameter int CELL_H = 40,
    parameter int SEG_T  = 4
) (
    input  logic       clk_dr,
    input  logic       rst_dr,
    input  logic       enable_dr,
    input  logic [2:0] mem_position_dr,
    input  logic [3:0] mem_id_dr,
    output logic [2:0] red_px_dr,
    output logic [2:0] green_px_dr,
    output logic [1:0] blue_px_dr,
    output logic       px_valid_dr
);

    localparam int XW = $clog2(CELL_W);
    localparam int YW = $clog2(CELL_H);
    localparam logic [XW-1:0] X_LAST = XW'(CELL_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(CELL_H - 1);

    logic [XW-1:0] x_q       [2];
    logic [YW-1:0] y_q       [2];
    logic [3:0]    digit_q   [2];
    logic [3:0]    cur_digit [2];
    logic [1:0]    act;
    logic [1:0]    first;
    logic [1:0]    pix_on;

    always_comb begin
        act = '0;
        if (enable_dr) begin
            case (mem_position_dr)
                POS_CELL0: act[0] = 1'b1;
                POS_CELL1: act[1] = 1'b1;
                POS_NULL:  act    = '0;
                default:   act    = '0;
            endcase
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_cell
        // On the first pixel the register is being loaded this cycle, so the
        // incoming id is used directly to keep the whole frame on one glyph.
        assign first[g]     = (x_q[g] == '0) && (y_q[g] == '0);
        assign cur_digit[g] = first[g] ? mem_id_dr : digit_q[g];

        seg_decode #(
            .CELL_W (CELL_W),
            .CELL_H (CELL_H),
            .SEG_T  (SEG_T),
            .XW     (XW),
            .YW     (YW)
        ) u_seg_decode (
            .digit  (cur_digit[g]),
            .x      (x_q[g]),
            .y      (y_q[g]),
            .pix_on (pix_on[g])
        );
    end

    always_ff @(posedge clk_dr) begin
        if (rst_dr || !enable_dr) begin
            for (int i = 0; i < 2; i++) begin
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                digit_q[i] <= ID_BLANK;
            end
            red_px_dr   <= '0;
            green_px_dr <= '0;
            blue_px_dr  <= '0;
            px_valid_dr <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (act[i]) begin
                    if (first[i]) begin
                        digit_q[i] <= mem_id_dr;
                    end
                    if (x_q[i] == X_LAST) begin
                        x_q[i] <= '0;
                        y_q[i] <= (y_q[i] == Y_LAST) ? '0 : y_q[i] + YW'(1);
                    end else begin
                        x_q[i] <= x_q[i] + XW'(1);
                    end
                end
            end
            if (act != 2'b00) begin
                px_valid_dr <= 1'b1;
                if ((act[0] && pix_on[0]) || (act[1] && pix_on[1])) begin
                    red_px_dr   <= FG_RED;
                    green_px_dr <= FG_GREEN;
                    blue_px_dr  <= FG_BLUE;
                end else begin
                    red_px_dr   <= BG_RED;
                    green_px_dr <= BG_GREEN;
                    blue_px_dr  <= BG_BLUE;
                end
            end else begin
                red_px_dr   <= '0;
                green_px_dr <= '0;
                blue_px_dr  <= '0;
                px_valid_dr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_digit_render.sv
// tb/tb_digit_render.sv - self-checking bench for digit_render
module tb_digit_render;

    localparam int W = 30;
    localparam int H = 40;
    localparam int T = 4;

    localparam logic [8:0] WHITE = {3'b111, 3'b111, 2'b11, 1'b1};
`ifdef DIGIT_RENDER_BG_EN
    localparam logic [8:0] BACK  = {3'b000, 3'b000, 2'b01, 1'b1};
`else
    localparam logic [8:0] BACK  = {3'b000, 3'b000, 2'b00, 1'b1};
`endif
    localparam logic [8:0] NONE  = 9'd0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [2:0] pos = 3'b111;
    logic [3:0] id  = 4'b1010;
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
    logic       valid;

    int checks   = 0;
    int failures = 0;

    int mx [2];
    int my [2];
    int md [2];
    logic [8:0] last_obs;
    logic [8:0] last_exp;

    always #5 clk = ~clk;

    digit_render dut (
        .clk_dr          (clk),
        .rst_dr          (rst),
        .enable_dr       (en),
        .mem_position_dr (pos),
        .mem_id_dr       (id),
        .red_px_dr       (red),
        .green_px_dr     (green),
        .blue_px_dr      (blue),
        .px_valid_dr     (valid)
    );

    // Segment letters lit for each digit, straight from the glyph list.
    function automatic string glyph(input int d);
        case (d)
            0: return "abcdef";
            1: return "bc";
            2: return "abdeg";
            3: return "abcdg";
            4: return "bcfg";
            5: return "acdfg";
            6: return "acdefg";
            7: return "abc";
            8: return "abcdefg";
            9: return "abcdfg";
            default: return "";
        endcase
    endfunction

    function automatic bit on_seg(input byte s, input int x, input int y);
        case (s)
            "a": return y < T && x >= T && x < W - T;
            "d": return y >= H - T && x >= T && x < W - T;
            "g": return y >= H/2 - T/2 && y < H/2 + T/2 && x >= T && x < W - T;
            "f": return x < T && y >= T && y < H/2 - T/2;
            "b": return x >= W - T && y >= T && y < H/2 - T/2;
            "e": return x < T && y >= H/2 + T/2 && y < H - T;
            "c": return x >= W - T && y >= H/2 + T/2 && y < H - T;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit lit(input int d, input int x, input int y);
        string s;
        s = glyph(d);
        for (int i = 0; i < s.len(); i++)
            if (on_seg(s[i], x, y)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict from the model, sample after the edge.
    task automatic step(input logic r, input logic e, input logic [2:0] p, input logic [3:0] d);
        int c;
        string tag;
        @(negedge clk);
        rst = r; en = e; pos = p; id = d;
        tag = "null";
        if (r || !e) begin
            mx = '{0, 0}; my = '{0, 0}; md = '{10, 10};
            last_exp = NONE;
            tag = r ? "reset" : "disabled";
        end else begin
            c = (p == 3'b000) ? 0 : (p == 3'b001) ? 1 : -1;
            if (c < 0) begin
                last_exp = NONE;
            end else begin
                if (mx[c] == 0 && my[c] == 0) md[c] = int'(d);
                last_exp = lit(md[c], mx[c], my[c]) ? WHITE : BACK;
                tag = $sformatf("c%0d_d%0d_(%0d,%0d)", c, md[c], mx[c], my[c]);
                mx[c]++;
                if (mx[c] == W) begin
                    mx[c] = 0;
                    my[c] = (my[c] == H - 1) ? 0 : my[c] + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        last_obs = {red, green, blue, valid};
        check(tag, last_obs, last_exp);
    endtask

    initial begin
        mx = '{0, 0}; my = '{0, 0}; md = '{10, 10};

        step(1, 0, 3'b000, 4'd8);
        step(1, 1, 3'b000, 4'd8);
        check("reset_zero", last_obs, NONE);

        // Full frame of digit 8 on cell 0.
        for (int k = 0; k < W * H; k++) begin
            step(0, 1, 3'b000, 4'd8);
            if (k == 0)          check("d8_p0_0",   last_obs, BACK);
            if (k == 1 * W + 10) check("d8_p10_1",  last_obs, WHITE);
            if (k == 19 * W + 10) check("d8_p10_19", last_obs, WHITE);
            if (k == 10 * W + 15) check("d8_p15_10", last_obs, BACK);
        end

        // Digit 1: only the right column lights.
        for (int k = 0; k < W * H; k++) begin
            step(0, 1, 3'b000, 4'd1);
            if (k == 10 * W + 2)  check("d1_p2_10",  last_obs, BACK);
            if (k == 10 * W + 27) check("d1_p27_10", last_obs, WHITE);
        end

        // Id change mid-frame must not alter the glyph until the next frame.
        for (int k = 0; k < 2 * W * H; k++) begin
            step(0, 1, 3'b000, (k < 5) ? 4'd0 : 4'd7);
            if (k == 10 * W + 2)         check("keep0_f",  last_obs, WHITE);
            if (k == W * H + 10 * W + 2) check("new7_f",   last_obs, BACK);
            if (k == W * H + 10 * W + 27) check("new7_b",  last_obs, WHITE);
        end

        // Interleaved rows of both cells.
        for (int row = 0; row < H; row++) begin
            for (int k = 0; k < W; k++) step(0, 1, 3'b000, 4'd3);
            for (int k = 0; k < W; k++) step(0, 1, 3'b001, 4'd9);
        end

        // Enable dropped mid-cell, then restart from the origin.
        for (int k = 0; k < 3 * W + 7; k++) step(0, 1, 3'b000, 4'd2);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 3'b000, 4'd2);
            check("en_low_zero", last_obs, NONE);
        end
        step(0, 1, 3'b000, 4'd4);
        check("reenable_origin", last_obs, BACK);
        for (int k = 0; k < 2 * W; k++) step(0, 1, 3'b000, 4'd4);

        // Null position and blank id.
        step(0, 1, 3'b111, 4'd5);
        check("pos_null", last_obs, NONE);
        step(0, 1, 3'b010, 4'd5);
        check("pos_other", last_obs, NONE);
        step(1, 1, 3'b000, 4'd0);
        for (int k = 0; k < W * H; k++) begin
            step(0, 1, 3'b000, 4'b1010);
            if (k == 1 * W + 10) check("blank_bg", last_obs, BACK);
        end

        // Randomised mix of positions, ids, enable and mid-cell resets.
        for (int k = 0; k < 4000; k++) begin
            logic [2:0] p;
            logic [3:0] d;
            int sel;
            sel = int'($urandom_range(0, 9));
            p = (sel < 4) ? 3'b000 : (sel < 8) ? 3'b001 : (sel == 8) ? 3'b111 : 3'($urandom);
            d = 4'($urandom_range(0, 11));
            step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1, p, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
